// File: rtl/recv_interval_if.sv
// Byte-strobe input and frame-status outputs between the byte receiver,
// the frame delimiter and the frame parser.
interface recv_interval_if #(
  parameter int unsigned LEN_W = 16
);
  logic             byte_valid;
  logic             frame_start;
  logic             frame_end;
  logic             gap_violation;
  logic [31:0]      gap_last;
  logic [LEN_W-1:0] frame_len;
  logic             busy;

  modport master (
    output byte_valid,
    input  frame_start, frame_end, gap_violation, gap_last, frame_len, busy
  );

  modport slave (
    input  byte_valid,
    output frame_start, frame_end, gap_violation, gap_last, frame_len, busy
  );
endinterface

// File: rtl/recv_interval.sv
// Splits a received byte stream into frames on an idle timeout and flags
// frames whose leading idle gap is shorter than the minimum interval.
module recv_interval #(
  parameter int unsigned LEN_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        INTERVAL,
  input  logic [31:0]        TIMEOUT,
  recv_interval_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FRAME = 2'b01
  } state_t;

  state_t state, state_nxt;

  logic [31:0]      gap_cnt, gap_cnt_d;
  logic [31:0]      idle_cnt, idle_cnt_d;
  logic [LEN_W-1:0] byte_cnt, byte_cnt_d;
  logic             first, first_d;

  logic             frame_start_q, frame_start_d;
  logic             frame_end_q, frame_end_d;
  logic             gap_violation_q, gap_violation_d;
  logic [31:0]      gap_last_q, gap_last_d;
  logic [LEN_W-1:0] frame_len_q, frame_len_d;
  logic             busy_q;

  logic [31:0] timeout_eff;
  logic [32:0] idle_inc;
  logic        timeout_hit;

  assign timeout_eff = (TIMEOUT == '0) ? 32'd1 : TIMEOUT;
  // Widened so the comparison stays correct even at the top of the 32-bit range
  assign idle_inc    = {1'b0, idle_cnt} + 33'd1;
  assign timeout_hit = idle_inc >= {1'b0, timeout_eff};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = bus.byte_valid ? FRAME : IDLE;
      FRAME:   state_nxt = (!bus.byte_valid && timeout_hit) ? IDLE : FRAME;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    gap_cnt_d       = gap_cnt;
    idle_cnt_d      = idle_cnt;
    byte_cnt_d      = byte_cnt;
    first_d         = first;
    frame_start_d   = 1'b0;
    frame_end_d     = 1'b0;
    gap_violation_d = 1'b0;
    gap_last_d      = gap_last_q;
    frame_len_d     = frame_len_q;
    case (state)
      IDLE: begin
        if (bus.byte_valid) begin
          frame_start_d   = 1'b1;
          gap_last_d      = gap_cnt;
          gap_violation_d = !first && (INTERVAL != '0) && (gap_cnt < INTERVAL);
          first_d         = 1'b0;
          byte_cnt_d      = {{(LEN_W-1){1'b0}}, 1'b1};
          idle_cnt_d      = '0;
        end else if (gap_cnt != '1) begin
          gap_cnt_d = gap_cnt + 32'd1;
        end
      end
      FRAME: begin
        if (bus.byte_valid) begin
          idle_cnt_d = '0;
          if (byte_cnt != '1) byte_cnt_d = byte_cnt + 1'b1;
        end else begin
          idle_cnt_d = idle_inc[31:0];
          if (timeout_hit) begin
            // Idle time already spent inside the frame counts toward the next gap
            frame_end_d = 1'b1;
            frame_len_d = byte_cnt;
            gap_cnt_d   = idle_inc[31:0];
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_cnt         <= '0;
      idle_cnt        <= '0;
      byte_cnt        <= '0;
      first           <= 1'b1;
      frame_start_q   <= 1'b0;
      frame_end_q     <= 1'b0;
      gap_violation_q <= 1'b0;
      gap_last_q      <= '0;
      frame_len_q     <= '0;
      busy_q          <= 1'b0;
    end else begin
      gap_cnt         <= gap_cnt_d;
      idle_cnt        <= idle_cnt_d;
      byte_cnt        <= byte_cnt_d;
      first           <= first_d;
      frame_start_q   <= frame_start_d;
      frame_end_q     <= frame_end_d;
      gap_violation_q <= gap_violation_d;
      gap_last_q      <= gap_last_d;
      frame_len_q     <= frame_len_d;
      busy_q          <= (state_nxt == FRAME);
    end
  end

  assign bus.frame_start   = frame_start_q;
  assign bus.frame_end     = frame_end_q;
  assign bus.gap_violation = gap_violation_q;
  assign bus.gap_last      = gap_last_q;
  assign bus.frame_len     = frame_len_q;
  assign bus.busy          = busy_q;

endmodule

// File: tb/tb_recv_interval.sv
// Directed bench for recv_interval: frame delimiting, gap measurement,
// timeout edge cases and mid-frame reset.
module tb_recv_interval;
  localparam int unsigned LEN_W = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] INTERVAL = 32'd50;
  logic [31:0] TIMEOUT = 32'd10;

  int unsigned n_tests = 0;
  int unsigned n_fail = 0;

  recv_interval_if #(.LEN_W(LEN_W)) bus ();

  recv_interval #(.LEN_W(LEN_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .INTERVAL (INTERVAL),
    .TIMEOUT  (TIMEOUT),
    .bus      (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle(input int unsigned n);
    bus.byte_valid = 1'b0;
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  task automatic send_byte();
    bus.byte_valid = 1'b1;
    tick();
    bus.byte_valid = 1'b0;
  endtask

  initial begin
    bus.byte_valid = 1'b0;
    tick();
    tick();
    check("rst_frame_start", {31'd0, bus.frame_start}, 32'd0);
    check("rst_frame_end",   {31'd0, bus.frame_end}, 32'd0);
    check("rst_gap_viol",    {31'd0, bus.gap_violation}, 32'd0);
    check("rst_gap_last",    bus.gap_last, 32'd0);
    check("rst_frame_len",   {16'd0, bus.frame_len}, 32'd0);
    check("rst_busy",        {31'd0, bus.busy}, 32'd0);
    rst_n = 1'b1;

    // Frame 1: first after reset, 3 idle cycles in front, 3 back-to-back bytes
    idle(3);
    send_byte();
    check("f1_start",     {31'd0, bus.frame_start}, 32'd1);
    check("f1_viol",      {31'd0, bus.gap_violation}, 32'd0);
    check("f1_gap_last",  bus.gap_last, 32'd3);
    check("f1_busy",      {31'd0, bus.busy}, 32'd1);
    bus.byte_valid = 1'b1;
    tick();
    check("f1_start_pulse", {31'd0, bus.frame_start}, 32'd0);
    tick();
    idle(9);
    check("f1_no_end_early", {31'd0, bus.frame_end}, 32'd0);
    check("f1_busy_hold",    {31'd0, bus.busy}, 32'd1);
    idle(1);
    check("f1_end",       {31'd0, bus.frame_end}, 32'd1);
    check("f1_len",       {16'd0, bus.frame_len}, 32'd3);
    check("f1_busy_low",  {31'd0, bus.busy}, 32'd0);
    idle(1);
    check("f1_end_pulse", {31'd0, bus.frame_end}, 32'd0);

    // Frame 2: 20 idle cycles after last byte (< 50) -> violation
    idle(9);
    send_byte();
    check("f2_start",    {31'd0, bus.frame_start}, 32'd1);
    check("f2_viol",     {31'd0, bus.gap_violation}, 32'd1);
    check("f2_gap_last", bus.gap_last, 32'd20);
    idle(10);
    check("f2_end",      {31'd0, bus.frame_end}, 32'd1);
    check("f2_len",      {16'd0, bus.frame_len}, 32'd1);

    // Frame 3: 60 idle cycles (>= 50) -> no violation
    idle(50);
    send_byte();
    check("f3_start",    {31'd0, bus.frame_start}, 32'd1);
    check("f3_viol",     {31'd0, bus.gap_violation}, 32'd0);
    check("f3_gap_last", bus.gap_last, 32'd60);

    // TIMEOUT=0 behaves as 1: every byte is its own frame
    TIMEOUT = 32'd0;
    idle(1);
    check("t0_end_a", {31'd0, bus.frame_end}, 32'd1);
    check("t0_len_a", {16'd0, bus.frame_len}, 32'd1);
    for (int unsigned k = 0; k < 3; k++) begin
      send_byte();
      check("t0_start",    {31'd0, bus.frame_start}, 32'd1);
      check("t0_gap_last", bus.gap_last, 32'd1);
      check("t0_viol",     {31'd0, bus.gap_violation}, 32'd1);
      idle(1);
      check("t0_end",      {31'd0, bus.frame_end}, 32'd1);
      check("t0_len",      {16'd0, bus.frame_len}, 32'd1);
    end

    // Byte lands on the TIMEOUT-th idle cycle: byte wins, frame continues
    TIMEOUT = 32'd4;
    send_byte();
    check("tb_start", {31'd0, bus.frame_start}, 32'd1);
    idle(3);
    send_byte();
    check("tb_no_end",   {31'd0, bus.frame_end}, 32'd0);
    check("tb_no_start", {31'd0, bus.frame_start}, 32'd0);
    check("tb_busy",     {31'd0, bus.busy}, 32'd1);
    idle(3);
    check("tb_no_end2",  {31'd0, bus.frame_end}, 32'd0);
    idle(1);
    check("tb_end",      {31'd0, bus.frame_end}, 32'd1);
    check("tb_len",      {16'd0, bus.frame_len}, 32'd2);

    // Reset mid-frame: frame dropped, next frame is an unchecked first frame
    INTERVAL = 32'd50;
    send_byte();
    check("rm_start", {31'd0, bus.frame_start}, 32'd1);
    idle(2);
    #2 rst_n = 1'b0;
    #1;
    check("rm_busy",     {31'd0, bus.busy}, 32'd0);
    check("rm_gap_last", bus.gap_last, 32'd0);
    check("rm_len",      {16'd0, bus.frame_len}, 32'd0);
    idle(3);
    check("rm_end_held", {31'd0, bus.frame_end}, 32'd0);
    rst_n = 1'b1;
    for (int unsigned i = 0; i < 5; i++) begin
      idle(1);
      check("rm_no_end", {31'd0, bus.frame_end}, 32'd0);
    end
    send_byte();
    check("rm_new_start", {31'd0, bus.frame_start}, 32'd1);
    check("rm_new_viol",  {31'd0, bus.gap_violation}, 32'd0);
    check("rm_gap_last2", bus.gap_last, 32'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "bench time limit reached");
  end
endmodule
